mm_result_packer: RTL

Downstream stage of the matrix-multiply core. Captures the core's per-element result stream (`out_data` qualified by `valid`, with `is_legal`, `change_row`, `busy`) and reassembles each result matrix (up to 4x4) into a ping-pong buffer. Replays each matrix as a framed, back-pressurable stream: a header word carrying legality and dimensions, then the elements in row-major order. Because the core cannot be stalled, the block absorbs one full matrix of drain latency and flags any matrix it must drop.

---
 rtl/mm_result_packer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mm_result_packer.sv
// Reassembles the matrix-multiply result stream into a two-bank ping-pong store and
// replays each matrix as a framed valid/ready stream: header word, then row-major elements.
module mm_result_packer (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [19:0] in_data,
  input  logic               in_valid,
  input  logic               in_legal,
  input  logic               in_row_end,
  input  logic               in_busy,
  output logic signed [19:0] o_data,
  output logic               o_valid,
  input  logic               o_ready,
  output logic               o_hdr,
  output logic               o_last,
  output logic               overflow
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_HDR, R_DATA} r_state_e;

  w_state_e    w_state_q;
  r_state_e    r_state_q;
  logic        wr_bank_q, rd_bank_q;
  logic [2:0]  row_q, col_q, cols_fix_q;
  logic        legal_acc_q, malf_acc_q;
  logic [1:0]  full_q, full_d;
  logic [1:0]  legal_q, malf_q;
  logic [2:0]  rows_q [2];
  logic [2:0]  cols_q [2];
  logic [19:0] mem_q [2][16];
  logic        overflow_q;
  logic [19:0] o_data_q;
  logic        o_valid_q, o_hdr_q, o_last_q;
  logic [1:0]  rr_q, rc_q;

  // Element bookkeeping: a fresh matrix in W_IDLE behaves as position (0,0).
  logic       idle, cur_legal, cur_malf, row_end, in_range;
  logic [2:0] cur_row, cur_col, cur_cols;
  logic [2:0] row_d, col_d, cols_d, rows_c;
  logic       malf_d, accept, commit, wr_en;

  always_comb begin
    idle      = (w_state_q == W_IDLE);
    cur_row   = idle ? 3'd0 : row_q;
    cur_col   = idle ? 3'd0 : col_q;
    cur_cols  = idle ? 3'd0 : cols_fix_q;
    cur_legal = idle ? in_legal : (legal_acc_q & in_legal);
    cur_malf  = idle ? 1'b0 : malf_acc_q;
    row_end   = in_row_end | ~in_busy;
    in_range  = (cur_row < 3'd4) && (cur_col < 3'd4);
    malf_d    = cur_malf | ~in_range;
    cols_d    = cur_cols;
    row_d     = cur_row;
    col_d     = cur_col;
    if (row_end) begin
      if (cur_row == 3'd0)
        cols_d = in_range ? cur_col + 3'd1 : 3'd4;
      else if (cur_col + 3'd1 != cur_cols)
        malf_d = 1'b1;
      row_d = (cur_row == 3'd4) ? 3'd4 : cur_row + 3'd1;
      col_d = 3'd0;
    end else begin
      col_d = (cur_col == 3'd4) ? 3'd4 : cur_col + 3'd1;
    end
    rows_c = (cur_row == 3'd4) ? 3'd4 : cur_row + 3'd1;
    accept = in_valid && ((w_state_q == W_FILL) || (idle && !full_q[wr_bank_q]));
    commit = accept && !in_busy;
    wr_en  = accept && cur_legal && in_range;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_bank_q][{cur_row[1:0], cur_col[1:0]}] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q   <= W_IDLE;
      wr_bank_q   <= 1'b0;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      cols_fix_q  <= 3'd0;
      legal_acc_q <= 1'b0;
      malf_acc_q  <= 1'b0;
      legal_q     <= 2'b00;
      malf_q      <= 2'b00;
      rows_q      <= '{default: 3'd0};
      cols_q      <= '{default: 3'd0};
      overflow_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE, W_FILL: begin
          if (in_valid && idle && full_q[wr_bank_q]) begin
            overflow_q <= 1'b1;
            if (in_busy) w_state_q <= W_DROP;
          end else if (accept) begin
            row_q       <= row_d;
            col_q       <= col_d;
            cols_fix_q  <= cols_d;
            legal_acc_q <= cur_legal;
            malf_acc_q  <= malf_d;
            if (commit) begin
              legal_q[wr_bank_q] <= cur_legal;
              malf_q[wr_bank_q]  <= cur_legal & malf_d;
              rows_q[wr_bank_q]  <= cur_legal ? rows_c : 3'd0;
              cols_q[wr_bank_q]  <= cur_legal ? cols_d : 3'd0;
              wr_bank_q          <= ~wr_bank_q;
              w_state_q          <= W_IDLE;
            end else begin
              w_state_q <= W_FILL;
            end
          end
        end
        W_DROP: if (in_valid && !in_busy) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Read side: header, then a walk over rows x cols with a stride-4 address.
  logic        rb, hdr_only, first_last, next_last, drain;
  logic [19:0] hdr_word;
  logic [1:0]  nr, nc;

  always_comb begin
    rb         = rd_bank_q;
    hdr_word   = {legal_q[rb], malf_q[rb], 12'b0, rows_q[rb], cols_q[rb]};
    hdr_only   = !legal_q[rb] || malf_q[rb];
    first_last = (rows_q[rb] == 3'd1) && (cols_q[rb] == 3'd1);
    if ({1'b0, rc_q} + 3'd1 == cols_q[rb]) begin
      nc = 2'd0;
      nr = rr_q + 2'd1;
    end else begin
      nc = rc_q + 2'd1;
      nr = rr_q;
    end
    next_last = ({1'b0, nr} + 3'd1 == rows_q[rb]) && ({1'b0, nc} + 3'd1 == cols_q[rb]);
    drain     = o_valid_q && o_ready && o_last_q;
    full_d    = full_q;
    if (drain)  full_d[rd_bank_q] = 1'b0;
    if (commit) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) full_q <= 2'b00;
    else      full_q <= full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      rd_bank_q <= 1'b0;
      o_data_q  <= 20'd0;
      o_valid_q <= 1'b0;
      o_hdr_q   <= 1'b0;
      o_last_q  <= 1'b0;
      rr_q      <= 2'd0;
      rc_q      <= 2'd0;
    end else begin
      case (r_state_q)
        R_IDLE: if (full_q[rd_bank_q]) begin
          r_state_q <= R_HDR;
          o_valid_q <= 1'b1;
          o_hdr_q   <= 1'b1;
          o_data_q  <= hdr_word;
          o_last_q  <= hdr_only;
        end
        R_HDR, R_DATA: if (o_ready) begin
          if (o_last_q) begin
            r_state_q <= R_IDLE;
            rd_bank_q <= ~rd_bank_q;
            o_valid_q <= 1'b0;
            o_hdr_q   <= 1'b0;
            o_last_q  <= 1'b0;
            o_data_q  <= 20'd0;
          end else if (r_state_q == R_HDR) begin
            r_state_q <= R_DATA;
            o_hdr_q   <= 1'b0;
            rr_q      <= 2'd0;
            rc_q      <= 2'd0;
            o_data_q  <= mem_q[rb][4'd0];
            o_last_q  <= first_last;
          end else begin
            rr_q     <= nr;
            rc_q     <= nc;
            o_data_q <= mem_q[rb][{nr, nc}];
            o_last_q <= next_last;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign o_data   = o_data_q;
  assign o_valid  = o_valid_q;
  assign o_hdr    = o_hdr_q;
  assign o_last   = o_last_q;
  assign overflow = overflow_q;

endmodule
